// File: rtl/pll_reset_seq.sv
// PLL lock monitor and system reset sequencer.
// Qualifies a synchronized lock, holds reset, then tracks losses/timeouts.
module pll_reset_seq #(
  parameter int SYNC_STAGES        = 2,
  parameter int LOCK_STABLE_CYCLES = 64,
  parameter int RESET_HOLD_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES     = 4096,
  parameter int LOSS_CNT_WIDTH     = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      locked,
  input  logic                      clear,
  output logic                      sys_rst_n,
  output logic                      ready,
  output logic                      lock_lost,
  output logic [LOSS_CNT_WIDTH-1:0] loss_count,
  output logic                      timeout,
  output logic [1:0]                state
);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } state_t;

  localparam int MAX_SH =
    (LOCK_STABLE_CYCLES > RESET_HOLD_CYCLES) ?
    LOCK_STABLE_CYCLES : RESET_HOLD_CYCLES;
  localparam int CNT_MAX =
    (TIMEOUT_CYCLES > MAX_SH) ? TIMEOUT_CYCLES : MAX_SH;
  localparam int CNT_W = $clog2(CNT_MAX + 1);

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [LOSS_CNT_WIDTH-1:0] loss_t;

  localparam cnt_t TO_LAST = cnt_t'(TIMEOUT_CYCLES - 1);
  localparam cnt_t TO_MAX  = cnt_t'(TIMEOUT_CYCLES);
  localparam cnt_t ST_LAST = cnt_t'(LOCK_STABLE_CYCLES - 1);
  localparam cnt_t HD_LAST = cnt_t'(RESET_HOLD_CYCLES - 1);
  localparam cnt_t CNT_ONE = cnt_t'(1);
  localparam loss_t LOSS_ONE = loss_t'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   locked_s;

  state_t state_q;
  state_t state_d;
  cnt_t   cnt_q;
  cnt_t   cnt_d;

  logic  sys_rst_n_q;
  logic  sys_rst_n_d;
  logic  lost_q;
  logic  lost_d;
  loss_t loss_q;
  loss_t loss_d;
  logic  tmo_q;
  logic  tmo_d;
  logic  tmo_set;

  // Only this chain ever looks at the raw lock input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], locked};
    end
  end

  assign locked_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WAIT_LOCK;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WAIT_LOCK: begin
        if (locked_s) state_d = STABLE;
      end
      STABLE: begin
        if (!locked_s)
          state_d = WAIT_LOCK;
        else if (cnt_q == ST_LAST)
          state_d = HOLD;
      end
      HOLD: begin
        if (!locked_s)
          state_d = WAIT_LOCK;
        else if (cnt_q == HD_LAST)
          state_d = RUN;
      end
      RUN: begin
        if (!locked_s) state_d = WAIT_LOCK;
      end
      default: state_d = WAIT_LOCK;
    endcase
  end

  // Shared counter: restarts on any state change.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (state_q == WAIT_LOCK) begin
      if (cnt_q != TO_MAX) cnt_d = cnt_q + CNT_ONE;
    end else if (state_q != RUN) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_comb begin
    sys_rst_n_d = (state_d == RUN);
    lost_d      = (state_q == RUN) && !locked_s;
    tmo_set     = (state_q == WAIT_LOCK) &&
                  (cnt_q == TO_LAST);
    tmo_d       = tmo_set | (tmo_q & ~clear);
    loss_d      = loss_q;
    if (clear) begin
      loss_d = lost_d ? LOSS_ONE : '0;
    end else if (lost_d && !(&loss_q)) begin
      loss_d = loss_q + LOSS_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sys_rst_n_q <= 1'b0;
      lost_q      <= 1'b0;
      loss_q      <= '0;
      tmo_q       <= 1'b0;
    end else begin
      sys_rst_n_q <= sys_rst_n_d;
      lost_q      <= lost_d;
      loss_q      <= loss_d;
      tmo_q       <= tmo_d;
    end
  end

  assign sys_rst_n  = sys_rst_n_q;
  assign ready      = sys_rst_n_q;
  assign lock_lost  = lost_q;
  assign loss_count = loss_q;
  assign timeout    = tmo_q;
  assign state      = state_q;

endmodule

// File: tb/tb_pll_reset_seq.sv
// Bench for pll_reset_seq: directed sequences plus random lock
// activity, compared cycle by cycle with a lock-run-length model.
module tb_pll_reset_seq;

  localparam int S = 2;
  localparam int L = 8;
  localparam int H = 4;
  localparam int T = 32;
  localparam int W = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         locked = 1'b0;
  logic         clear = 1'b0;
  logic         sys_rst_n;
  logic         ready;
  logic         lock_lost;
  logic [W-1:0] loss_count;
  logic         timeout;
  logic [1:0]   state;

  always #5 clk = ~clk;

  pll_reset_seq #(
    .SYNC_STAGES       (S),
    .LOCK_STABLE_CYCLES(L),
    .RESET_HOLD_CYCLES (H),
    .TIMEOUT_CYCLES    (T),
    .LOSS_CNT_WIDTH    (W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .locked    (locked),
    .clear     (clear),
    .sys_rst_n (sys_rst_n),
    .ready     (ready),
    .lock_lost (lock_lost),
    .loss_count(loss_count),
    .timeout   (timeout),
    .state     (state)
  );

  int checks = 0;
  int failures = 0;

  // Model: delay line of raw lock, length of the current high run of
  // the synchronized lock, and time spent waiting without lock.
  bit pipe[S];
  int run_len;
  int wait_age;
  int m_st;
  int m_loss;
  bit m_tmo;
  bit m_lost;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic int phase_of(input int r);
    if (r == 0) return 0;
    if (r <= L) return 1;
    if (r <= L + H) return 2;
    return 3;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < S; i++) pipe[i] = 1'b0;
    run_len  = 0;
    wait_age = 0;
    m_st     = 0;
    m_loss   = 0;
    m_tmo    = 1'b0;
    m_lost   = 1'b0;
  endtask

  task automatic model_edge();
    bit ls;
    bit inc;
    bit set;
    int nst;
    ls = pipe[S-1];
    for (int i = S - 1; i > 0; i--) pipe[i] = pipe[i-1];
    pipe[0] = locked;
    run_len = ls ? ((run_len < 100000) ? run_len + 1 : run_len) : 0;
    nst = phase_of(run_len);
    inc = (m_st == 3) && !ls;
    set = (m_st == 0) && (wait_age + 1 == T);
    if (m_st == 0 && nst == 0)
      wait_age = (wait_age < 100000) ? wait_age + 1 : wait_age;
    else
      wait_age = 0;
    m_lost = inc;
    if (clear)
      m_loss = inc ? 1 : 0;
    else if (inc && m_loss < (1 << W) - 1)
      m_loss++;
    m_tmo = set | (m_tmo & !clear);
    m_st = nst;
  endtask

  task automatic cmp_all();
    chk("state", 32'(state), 32'(m_st));
    chk("sys_rst_n", 32'(sys_rst_n), 32'(m_st == 3));
    chk("ready", 32'(ready), 32'(m_st == 3));
    chk("lock_lost", 32'(lock_lost), 32'(m_lost));
    chk("loss_count", 32'(loss_count), 32'(m_loss));
    chk("timeout", 32'(timeout), 32'(m_tmo));
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    cmp_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    cmp_all();
    step();
    rst_n = 1'b1;
  endtask

  task automatic wait_sys(input logic want, output int n);
    n = 0;
    while (sys_rst_n !== want && n < 200) begin
      step();
      n++;
    end
  endtask

  task automatic lose(input int k);
    int n;
    int pulses;
    locked = 1'b0;
    n = 0;
    pulses = 0;
    while (sys_rst_n !== 1'b0 && n < 50) begin
      step();
      n++;
      pulses += int'(lock_lost);
    end
    step();
    pulses += int'(lock_lost);
    chk("t3_drop_lat", 32'(n), 32'd3);
    chk("t3_pulse", 32'(pulses), 32'd1);
    chk("t3_loss", 32'(loss_count), 32'((k > 3) ? 3 : k));
    locked = 1'b1;
    wait_sys(1'b1, n);
    chk("t3_relock", 32'(n), 32'd15);
  endtask

  initial begin
    int n;
    int code;
    int last;
    bit saw;
    int hold;

    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    cmp_all();
    step();
    step();
    rst_n = 1'b1;

    // Normal qualification and state sequence.
    repeat (10) step();
    locked = 1'b1;
    n = 0;
    code = 0;
    last = int'(state);
    while (sys_rst_n !== 1'b1 && n < 200) begin
      step();
      n++;
      if (int'(state) != last) begin
        last = int'(state);
        code = code * 4 + last;
      end
    end
    chk("t1_latency", 32'(n), 32'd15);
    chk("t1_states", 32'(code), 32'd27);
    chk("t1_ready", 32'(ready), 32'd1);

    // Short lock glitch: qualification restarts, no loss.
    do_reset();
    saw = 1'b0;
    locked = 1'b1;
    repeat (5) begin
      step();
      saw |= lock_lost;
    end
    locked = 1'b0;
    repeat (4) begin
      step();
      saw |= lock_lost;
    end
    chk("t2_state", 32'(state), 32'd0);
    chk("t2_loss", 32'(loss_count), 32'd0);
    locked = 1'b1;
    n = 0;
    while (sys_rst_n !== 1'b1 && n < 200) begin
      step();
      n++;
      saw |= lock_lost;
    end
    chk("t2_latency", 32'(n), 32'd15);
    chk("t2_no_lost", 32'(saw), 32'd0);

    // Losses in RUN, counter saturation.
    for (int k = 1; k <= 4; k++) lose(k);
    chk("t3_sat", 32'(loss_count), 32'd3);

    // Timeout while waiting, then clear.
    do_reset();
    locked = 1'b0;
    repeat (31) step();
    chk("t4_pre", 32'(timeout), 32'd0);
    step();
    chk("t4_set", 32'(timeout), 32'd1);
    repeat (8) step();
    chk("t4_sticky", 32'(timeout), 32'd1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("t4_clear", 32'(timeout), 32'd0);
    locked = 1'b1;
    wait_sys(1'b1, n);
    chk("t4_latency", 32'(n), 32'd15);

    // Async reset during HOLD.
    do_reset();
    locked = 1'b1;
    repeat (13) step();
    chk("t5_hold", 32'(state), 32'd2);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("t5_state", 32'(state), 32'd0);
    chk("t5_sys", 32'(sys_rst_n), 32'd0);
    cmp_all();
    step();
    rst_n = 1'b1;
    wait_sys(1'b1, n);
    chk("t5_latency", 32'(n), 32'd15);

    // Clear coinciding with a loss.
    lose(1);
    lose(2);
    locked = 1'b0;
    step();
    step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("t6_lost", 32'(lock_lost), 32'd1);
    chk("t6_loss", 32'(loss_count), 32'd1);
    locked = 1'b1;
    wait_sys(1'b1, n);

    // Random lock activity, clears and resets.
    hold = 0;
    for (int c = 0; c < 1500; c++) begin
      if (hold == 0) begin
        locked = 1'($urandom_range(0, 1));
        hold = int'($urandom_range(1, 30));
      end
      hold--;
      clear = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 299) == 0) do_reset();
      step();
    end
    clear = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
